vram_port_arbiter: RTL and testbench

- Shares one single-port, 1-cycle-read-latency on-chip RAM (256x16 class) between NUM_REQ requesters, e.g. CPU write path, scanout fetch and blitter.
- Arbitration is round-robin with optional short bursts: a winner may hold the port for up to MAX_BURST consecutive beats.
- Drives the RAM port directly and routes read data back to the requester that issued the read.
- Sits between the GPU client blocks and the inferred RAM instance.

---
 rtl/vram_arb_pkg.sv | 27 ++
 rtl/vram_port_arbiter_rr_pick.sv | 43 ++++
 rtl/vram_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_vram_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arb_pkg.sv
// ----------------------------------------------------------------------------
// vram_arb_pkg
// Shared types, default parameters and helper function for the VRAM port
// arbiter.
//   arb_state_e  : arbiter FSM state (IDLE / BURST)
//   DEF_*        : default parameter values used by vram_port_arbiter
//   rr_next()    : round-robin pointer advance, (ptr + 1) mod n
// ----------------------------------------------------------------------------
package vram_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   localparam int DEF_NUM_REQ   = 4;
   localparam int DEF_ADDR_W    = 8;
   localparam int DEF_DATA_W    = 16;
   localparam int DEF_MAX_BURST = 4;
   localparam int PERF_W        = 16;

   // Wraps correctly for non-power-of-two requester counts.
   function automatic int rr_next(input int ptr, input int n);
      return (ptr + 1) % n;
   endfunction

endpackage

// File: rtl/vram_port_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: the first set bit of req, scanning from
// index ptr upward and wrapping modulo N.
// Ports:
//   req     in  N      request vector
//   ptr     in  PTR_W  starting index of the scan (must be < N)
//   grant   out N      one-hot grant (all zero when no request)
//   idx     out PTR_W  winner index (0 when no request)
//   any_req out 1      at least one request present
// ----------------------------------------------------------------------------
module rr_pick #(
   parameter  int N     = 4,
   localparam int PTR_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [PTR_W-1:0] idx,
   output logic             any_req
);

   int j;

   // NOTE: every variable written in always_comb gets a default first, so
   //       no path through the block can leave it unassigned (no latch).
   always_comb begin
      grant   = '0;
      idx     = '0;
      any_req = 1'b0;
      j       = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (!any_req && req[j]) begin
            any_req  = 1'b1;
            grant[j] = 1'b1;
            idx      = PTR_W'(j);
         end
      end
   end

endmodule

// File: rtl/vram_port_arbiter.sv
// ----------------------------------------------------------------------------
// vram_port_arbiter
// Shares one single-port, 1-cycle-read-latency RAM between NUM_REQ
// requesters with round-robin arbitration and bursts of up to MAX_BURST
// beats. Drives the RAM port combinationally from the accepted beat and
// routes read data back to the requester that issued the read.
// Optional build macro VRAM_ARB_PERF_EN adds per-requester saturating
// accepted-beat counters (perf_clr / perf_beats).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req_valid    in  NUM_REQ         per-requester beat valid
//   req_ready    out NUM_REQ         beat accept (at most one bit set)
//   req_we       in  NUM_REQ         1=write, 0=read
//   req_last     in  NUM_REQ         final beat of a burst
//   req_addr     in  NUM_REQ*ADDR_W  packed addresses
//   req_wdata    in  NUM_REQ*DATA_W  packed write data
//   rsp_valid    out NUM_REQ         read data valid, one cycle after accept
//   rsp_rdata    out DATA_W          shared read data
//   mem_addr/mem_din/mem_we  out     RAM port
//   mem_dout     in  DATA_W          RAM read data
//   perf_clr     in  1               (VRAM_ARB_PERF_EN) synchronous counter clear
//   perf_beats   out NUM_REQ*16      (VRAM_ARB_PERF_EN) accepted-beat counters
// ----------------------------------------------------------------------------
module vram_port_arbiter
   import vram_arb_pkg::*;
#(
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int MAX_BURST = DEF_MAX_BURST
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [NUM_REQ-1:0]    req_we,
   input  logic [NUM_REQ-1:0]    req_last,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]    rsp_valid,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_din,
   output logic                  mem_we,
   input  logic [DATA_W-1:0]     mem_dout
`ifdef VRAM_ARB_PERF_EN
  ,input  logic                  perf_clr
  ,output logic [NUM_REQ*PERF_W-1:0] perf_beats
`endif
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   arb_state_e         state, state_d;
   logic [PTR_W-1:0]   rr_ptr, rr_ptr_d;
   logic [PTR_W-1:0]   owner, owner_d;
   logic [CNT_W-1:0]   beat_cnt, beat_cnt_d, beat_inc;
   logic [NUM_REQ-1:0] pick_grant;
   logic [PTR_W-1:0]   pick_idx;
   logic               any_req;
   logic               acc;
   logic [PTR_W-1:0]   acc_idx;

   rr_pick #(.N(NUM_REQ)) u_pick (
      .req     (req_valid),
      .ptr     (rr_ptr),
      .grant   (pick_grant),
      .idx     (pick_idx),
      .any_req (any_req)
   );

   assign beat_inc = beat_cnt + CNT_W'(1);

   // Next-state and accept decode. A bubble from the burst owner releases
   // the port; arbitration resumes on the following cycle.
   always_comb begin
      state_d    = state;
      rr_ptr_d   = rr_ptr;
      owner_d    = owner;
      beat_cnt_d = beat_cnt;
      req_ready  = '0;
      acc        = 1'b0;
      acc_idx    = '0;
      unique case (state)
         IDLE: begin
            if (any_req) begin
               req_ready = pick_grant;
               acc       = 1'b1;
               acc_idx   = pick_idx;
               if (req_last[pick_idx] || MAX_BURST == 1) begin
                  rr_ptr_d = PTR_W'(rr_next(int'(pick_idx), NUM_REQ));
               end else begin
                  state_d    = BURST;
                  owner_d    = pick_idx;
                  beat_cnt_d = CNT_W'(1);
               end
            end
         end
         BURST: begin
            if (req_valid[owner]) begin
               req_ready[owner] = 1'b1;
               acc              = 1'b1;
               acc_idx          = owner;
               beat_cnt_d       = beat_inc;
               if (req_last[owner] || beat_inc == CNT_W'(MAX_BURST)) begin
                  state_d  = IDLE;
                  rr_ptr_d = PTR_W'(rr_next(int'(owner), NUM_REQ));
               end
            end else begin
               state_d  = IDLE;
               rr_ptr_d = PTR_W'(rr_next(int'(owner), NUM_REQ));
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // RAM port is a straight copy of the accepted beat, zero otherwise.
   always_comb begin
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_din  = '0;
      if (acc) begin
         mem_we   = req_we[acc_idx];
         mem_addr = req_addr[int'(acc_idx)*ADDR_W +: ADDR_W];
         mem_din  = req_wdata[int'(acc_idx)*DATA_W +: DATA_W];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   //       samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         owner    <= '0;
         beat_cnt <= '0;
      end else begin
         state    <= state_d;
         rr_ptr   <= rr_ptr_d;
         owner    <= owner_d;
         beat_cnt <= beat_cnt_d;
      end
   end

   // The RAM returns data one cycle after the read address; remember who
   // asked so the shared data bus can be qualified per requester.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= '0;
      end else begin
         rsp_valid <= '0;
         if (acc && !req_we[acc_idx]) rsp_valid[acc_idx] <= 1'b1;
      end
   end

   assign rsp_rdata = mem_dout;

`ifdef VRAM_ARB_PERF_EN
   logic [PERF_W-1:0] perf_cnt [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            perf_cnt[g] <= '0;
         end else if (perf_clr) begin
            perf_cnt[g] <= '0;
         end else if (req_valid[g] && req_ready[g] && perf_cnt[g] != '1) begin
            perf_cnt[g] <= perf_cnt[g] + PERF_W'(1);
         end
      end
      assign perf_beats[g*PERF_W +: PERF_W] = perf_cnt[g];
   end
`endif

endmodule

// File: tb/tb_vram_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_vram_port_arbiter
// Self-checking bench for vram_port_arbiter (default parameters). A
// behavioural RAM is attached to the RAM port; a reference model of the
// arbitration rules predicts req_ready, the RAM port and read responses.
// ----------------------------------------------------------------------------
module tb_vram_port_arbiter;

   localparam int N  = 4;
   localparam int AW = 8;
   localparam int DW = 16;
   localparam int MB = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [N-1:0]    req_valid, req_ready, req_we, req_last, rsp_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [DW-1:0]   rsp_rdata, mem_din, mem_dout;
   logic [AW-1:0]   mem_addr;
   logic            mem_we;
`ifdef VRAM_ARB_PERF_EN
   logic            perf_clr;
   logic [N*16-1:0] perf_beats;
`endif

   vram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_last  (req_last),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .mem_we    (mem_we),
      .mem_dout  (mem_dout)
`ifdef VRAM_ARB_PERF_EN
     ,.perf_clr   (perf_clr)
     ,.perf_beats (perf_beats)
`endif
   );

   // Behavioural single-port RAM, 1-cycle read latency.
   logic [DW-1:0] ram [256];
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      mem_dout <= ram[mem_addr];
   end

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int            m_ptr, m_owner, m_beats;
   bit            m_burst;
   logic [DW-1:0] m_ram [256];
   bit            m_known [256];
   logic [N-1:0]  exp_rsp_v;
   logic [DW-1:0] exp_rsp_d;
   bit            exp_rsp_known;
   logic [N-1:0]  last_ready;
   int            last_win;

   task automatic model_reset();
      m_ptr = 0; m_owner = 0; m_beats = 0; m_burst = 0;
      exp_rsp_v = '0; exp_rsp_d = '0; exp_rsp_known = 0;
   endtask

   task automatic clear_all();
      req_valid = '0; req_we = '0; req_last = '0; req_addr = '0; req_wdata = '0;
   endtask

   task automatic drive(input int i, input bit v, input bit we, input bit last,
                        input int addr, input int data);
      req_valid[i] = v;
      req_we[i]    = we;
      req_last[i]  = last;
      req_addr[i*AW +: AW]  = AW'(addr);
      req_wdata[i*DW +: DW] = DW'(data);
   endtask

   // One clock: checks the cycle's combinational outputs and the response
   // due from the previous cycle, then advances the model.
   task automatic step();
      int win, j;
      logic [N-1:0]  er;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      logic          ewe;
      @(negedge clk);
      win = -1;
      if (!m_burst) begin
         for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (win < 0 && req_valid[j]) win = j;
         end
         if (win >= 0) begin
            if (req_last[win] || MB == 1) m_ptr = (win + 1) % N;
            else begin m_burst = 1; m_owner = win; m_beats = 1; end
         end
      end else begin
         m_burst = 0;
         if (req_valid[m_owner]) begin
            win = m_owner;
            m_beats++;
            if (!(req_last[win] || m_beats == MB)) m_burst = 1;
         end
         if (!m_burst) m_ptr = (m_owner + 1) % N;
      end
      er = '0; ea = '0; ed = '0; ewe = 1'b0;
      if (win >= 0) begin
         er[win] = 1'b1;
         ea  = req_addr[win*AW +: AW];
         ed  = req_wdata[win*DW +: DW];
         ewe = req_we[win];
      end
      check("req_ready", req_ready, er);
      check("mem_we",    mem_we,    ewe);
      check("mem_addr",  mem_addr,  ea);
      check("mem_din",   mem_din,   ed);
      check("rsp_valid", rsp_valid, exp_rsp_v);
      if (exp_rsp_v != '0 && exp_rsp_known) check("rsp_rdata", rsp_rdata, exp_rsp_d);
      exp_rsp_v = '0;
      if (win >= 0 && !ewe) begin
         exp_rsp_v[win] = 1'b1;
         exp_rsp_d      = m_ram[ea];
         exp_rsp_known  = m_known[ea];
      end
      if (win >= 0 && ewe) begin
         m_ram[ea]   = ed;
         m_known[ea] = 1;
      end
      last_ready = req_ready;
      last_win   = win;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear_all();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int seq[$];
      int exp_seq[7];
      int b;
      bit served3;
`ifdef VRAM_ARB_PERF_EN
      perf_clr = 1'b0;
`endif
      for (int i = 0; i < 256; i++) m_known[i] = 0;
      clear_all();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready",     req_ready, '0);
      check("rst_rsp_valid", rsp_valid, '0);
      check("rst_mem_we",    mem_we,    '0);
      check("rst_mem_addr",  mem_addr,  '0);
      check("rst_mem_din",   mem_din,   '0);
      rst_n = 1'b1;
      model_reset();

      // Single read: write 0xBEEF to 0x10, then read it back from requester 2.
      drive(2, 1, 1, 1, 'h10, 'hBEEF); step();
      clear_all(); step();
      drive(2, 1, 0, 1, 'h10, 0); step();
      check("single_ready", last_ready, 4'b0100);
      check("single_rsp_v", rsp_valid,  4'b0100);
      check("single_rdata", rsp_rdata,  16'hBEEF);
      clear_all();
      for (int i = 0; i < N; i++) drive(i, 1, 1, 1, 'h80 + i, 'h100 + i);
      step();
      check("single_rr_ptr3", last_ready, 4'b1000);

      // Round-robin from reset, all requesters valid with last=1.
      do_reset();
      for (int i = 0; i < N; i++) drive(i, 1, 1, 1, 'h50 + i, 'h200 + i);
      for (int k = 0; k < 5; k++) begin
         step();
         check("rr_order", last_ready, 4'b0001 << (k % 4));
      end

      // Burst: requester 1 six writes, requester 3 also waiting.
      do_reset();
      b = 0; served3 = 0;
      for (int cyc = 0; cyc < 20 && b < 6; cyc++) begin
         clear_all();
         drive(1, 1, 1, (b == 5), 'h20 + b, 'hA000 + b);
         if (!served3) drive(3, 1, 1, 1, 'h40, 'h3333);
         step();
         if (last_win >= 0) seq.push_back(last_win);
         if (last_ready[1]) b++;
         if (last_ready[3]) served3 = 1;
      end
      check("burst_done", b, 6);
      exp_seq = '{1, 1, 1, 1, 3, 1, 1};
      check("burst_len", seq.size(), 7);
      for (int i = 0; i < 7 && i < seq.size(); i++) check("burst_order", seq[i], exp_seq[i]);
      for (int k = 0; k < 6; k++) begin
         clear_all();
         drive(1, 1, 0, 1, 'h20 + k, 0);
         step();
         check("burst_ram", rsp_rdata, 16'hA000 + k);
      end
      clear_all(); step();

      // Burst abort: requester 0 bubbles after beat 2, requester 1 waiting.
      do_reset();
      drive(0, 1, 1, 0, 'h60, 'h1);
      drive(1, 1, 0, 1, 'h20, 0);
      step(); check("abort_b1", last_ready, 4'b0001);
      drive(0, 1, 1, 0, 'h61, 'h2);
      step(); check("abort_b2", last_ready, 4'b0001);
      req_valid[0] = 1'b0;
      step(); check("abort_gap", last_ready, 4'b0000);
      step(); check("abort_next", last_ready, 4'b0010);
      clear_all(); step();

      // Reset mid-operation: rsp_valid from an accepted read is dropped.
      drive(2, 1, 0, 1, 'h10, 0); step();
      clear_all();
      rst_n = 1'b0;
      #1;
      check("midrst_rsp_now", rsp_valid, '0);
      @(posedge clk); #1;
      check("midrst_rsp_held", rsp_valid, '0);
      rst_n = 1'b1;
      model_reset();
      check("midrst_rsp_rel", rsp_valid, '0);
      for (int i = 0; i < N; i++) drive(i, 1, 1, 1, 'h70 + i, 'h300 + i);
      step(); check("midrst_rr0", last_ready, 4'b0001);

      // Randomized traffic against the model.
      do_reset();
      for (int cyc = 0; cyc < 1500; cyc++) begin
         clear_all();
         for (int i = 0; i < N; i++)
            drive(i, ($urandom_range(0, 9) < 6), $urandom_range(0, 1),
                  ($urandom_range(0, 2) == 0), $urandom_range(0, 31), $urandom);
         step();
      end
      clear_all(); step(); step();

`ifdef VRAM_ARB_PERF_EN
      do_reset();
      drive(0, 1, 1, 1, 'h05, 'h55);
      repeat (70000) @(posedge clk);
      #1;
      check("perf_sat",   perf_beats[15:0],  16'hFFFF);
      check("perf_other", perf_beats[31:16], 16'h0000);
      perf_clr = 1'b1;
      @(posedge clk); #1;
      perf_clr = 1'b0;
      check("perf_clr", perf_beats[15:0], 16'h0000);
      @(posedge clk); #1;
      check("perf_inc", perf_beats[15:0], 16'h0001);
      clear_all();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
